// File: rtl/fft_magnitude_pipe.sv
// fft_magnitude_pipe
//   Streaming magnitude |X| = sqrt(re^2 + im^2) for FFT output bins, fully
//   integer. Pipeline: input register, squares, sum, W digit-recurrence
//   square-root stages (one root bit per stage, MSB first, remainder carried),
//   output register. Latency is W+4 enabled cycles. A tag/last/valid shift
//   register of the same depth rides alongside. A peak detector tracks the
//   largest magnitude per frame (frame closed by last) on output transfers.
//
//   Build option: define FFT_MAG_ROUND_EN to round the root to nearest
//   (half-up) in the output stage; otherwise the result is floor(sqrt).
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   real_in, imag_in  signed W-bit sample, with tag_in/last_in/valid_in
//   ready_out         input accepted when valid_in & ready_out
//   magnitude_out     unsigned W-bit magnitude, with tag_out/last_out/valid_out
//   ready_in          downstream ready
//   peak_mag/peak_tag largest bin of the last completed frame
//   peak_valid        one-cycle pulse when peak_mag/peak_tag update
module fft_magnitude_pipe #(
    parameter int W     = 20,
    parameter int TAG_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] real_in,
    input  logic signed [W-1:0] imag_in,
    input  logic [TAG_W-1:0]    tag_in,
    input  logic                last_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic [W-1:0]        magnitude_out,
    output logic [TAG_W-1:0]    tag_out,
    output logic                last_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic [W-1:0]        peak_mag,
    output logic [TAG_W-1:0]    peak_tag,
    output logic                peak_valid
);

    localparam int P   = W + 4;  // pipeline depth
    localparam int SW  = 2 * W;  // sum width
    localparam int RMW = W + 1;  // stored remainder width (rem <= 2*root)
    localparam int RW  = W + 3;  // remainder width during a stage

    logic                en;
    logic [P-1:0]        vld_q;
    logic [P-1:0]        last_q;
    logic [TAG_W-1:0]    tag_q [0:P-1];

    logic signed [W-1:0] re1_q, im1_q;
    logic [W-1:0]        abs_re, abs_im;
    logic [SW-2:0]       sq_re_d, sq_im_d, sq_re_q, sq_im_q;
    logic [SW-1:0]       sum_d, sum_q;

    logic [SW-1:0]       rad_d  [1:W-1];
    logic [SW-1:0]       rad_q  [1:W-1];
    logic [RMW-1:0]      rem_d  [1:W];
    logic [RMW-1:0]      rem_q  [1:W];
    logic [W-1:0]        root_d [1:W];
    logic [W-1:0]        root_q [1:W];

    logic [W-1:0]        mag_d, mag_q;

    // Whole pipeline stalls together; bubbles are not squeezed out.
    assign en        = ~vld_q[P-1] | ready_in;
    assign ready_out = en;

    // Negating the most negative value wraps to the same bit pattern, which
    // read as unsigned is exactly 2^(W-1).
    assign abs_re  = re1_q[W-1] ? $unsigned(-re1_q) : $unsigned(re1_q);
    assign abs_im  = im1_q[W-1] ? $unsigned(-im1_q) : $unsigned(im1_q);
    assign sq_re_d = (SW-1)'(abs_re) * (SW-1)'(abs_re);
    assign sq_im_d = (SW-1)'(abs_im) * (SW-1)'(abs_im);
    assign sum_d   = SW'(sq_re_q) + SW'(sq_im_q);

    // Stage k brings down the next two radicand bits and tries root bit k.
    for (genvar k = 0; k < W; k++) begin : g_sqrt
        logic [SW-1:0]  rad_in;
        logic [RMW-1:0] rem_in;
        logic [W-1:0]   root_in;
        logic [RW-1:0]  rem_sh;
        logic [RW-1:0]  trial;
        logic           ge;

        if (k == 0) begin : g_head
            assign rad_in  = sum_q;
            assign rem_in  = '0;
            assign root_in = '0;
        end else begin : g_body
            assign rad_in  = rad_q[k];
            assign rem_in  = rem_q[k];
            assign root_in = root_q[k];
        end

        assign rem_sh        = {rem_in, rad_in[SW-1:SW-2]};
        assign trial         = {1'b0, root_in, 2'b01};
        assign ge            = (rem_sh >= trial);
        assign rem_d[k+1]    = ge ? RMW'(rem_sh - trial) : RMW'(rem_sh);
        assign root_d[k+1]   = {root_in[W-2:0], ge};

        if (k < W - 1) begin : g_rad
            assign rad_d[k+1] = {rad_in[SW-3:0], 2'b00};
        end else begin : g_tail
            logic unused_rad;
            assign unused_rad = ^rad_in[SW-3:0];
        end
    end

`ifdef FFT_MAG_ROUND_EN
    // sqrt(N) >= root + 1/2  <=>  N - root^2 > root for integer N.
    assign mag_d = (rem_q[W] > {1'b0, root_q[W]}) ? root_q[W] + W'(1) : root_q[W];
`else
    logic unused_rem;
    assign unused_rem = ^rem_q[W];
    assign mag_d      = root_q[W];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= '0;
            last_q  <= '0;
            for (int i = 0; i < P; i++) tag_q[i] <= '0;
            re1_q   <= '0;
            im1_q   <= '0;
            sq_re_q <= '0;
            sq_im_q <= '0;
            sum_q   <= '0;
            for (int k = 1; k < W; k++) rad_q[k] <= '0;
            for (int k = 1; k <= W; k++) begin
                rem_q[k]  <= '0;
                root_q[k] <= '0;
            end
            mag_q   <= '0;
        end else if (en) begin
            vld_q   <= {vld_q[P-2:0], valid_in};
            last_q  <= {last_q[P-2:0], last_in};
            tag_q[0] <= tag_in;
            for (int i = 1; i < P; i++) tag_q[i] <= tag_q[i-1];
            re1_q   <= real_in;
            im1_q   <= imag_in;
            sq_re_q <= sq_re_d;
            sq_im_q <= sq_im_d;
            sum_q   <= sum_d;
            for (int k = 1; k < W; k++) rad_q[k] <= rad_d[k];
            for (int k = 1; k <= W; k++) begin
                rem_q[k]  <= rem_d[k];
                root_q[k] <= root_d[k];
            end
            mag_q   <= mag_d;
        end
    end

    assign valid_out     = vld_q[P-1];
    assign last_out      = last_q[P-1];
    assign tag_out       = tag_q[P-1];
    assign magnitude_out = mag_q;

    // Peak detector. run_act_q marks that the current frame has seen a bin,
    // so the first bin always loads even when its magnitude is zero.
    logic              xfer, take;
    logic [W-1:0]      run_max_q, run_max_d, sel_mag;
    logic [TAG_W-1:0]  run_tag_q, run_tag_d, sel_tag;
    logic              run_act_q, run_act_d;
    logic [W-1:0]      pk_mag_q, pk_mag_d;
    logic [TAG_W-1:0]  pk_tag_q, pk_tag_d;
    logic              pk_vld_q, pk_vld_d;

    assign xfer    = vld_q[P-1] & ready_in;
    assign take    = ~run_act_q | (mag_q > run_max_q);
    assign sel_mag = take ? mag_q : run_max_q;
    assign sel_tag = take ? tag_q[P-1] : run_tag_q;

    always_comb begin
        run_max_d = run_max_q;
        run_tag_d = run_tag_q;
        run_act_d = run_act_q;
        pk_mag_d  = pk_mag_q;
        pk_tag_d  = pk_tag_q;
        pk_vld_d  = 1'b0;
        if (xfer) begin
            if (last_q[P-1]) begin
                pk_mag_d  = sel_mag;
                pk_tag_d  = sel_tag;
                pk_vld_d  = 1'b1;
                run_max_d = '0;
                run_act_d = 1'b0;
            end else begin
                run_max_d = sel_mag;
                run_tag_d = sel_tag;
                run_act_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_max_q <= '0;
            run_tag_q <= '0;
            run_act_q <= 1'b0;
            pk_mag_q  <= '0;
            pk_tag_q  <= '0;
            pk_vld_q  <= 1'b0;
        end else begin
            run_max_q <= run_max_d;
            run_tag_q <= run_tag_d;
            run_act_q <= run_act_d;
            pk_mag_q  <= pk_mag_d;
            pk_tag_q  <= pk_tag_d;
            pk_vld_q  <= pk_vld_d;
        end
    end

    assign peak_mag   = pk_mag_q;
    assign peak_tag   = pk_tag_q;
    assign peak_valid = pk_vld_q;

endmodule

// File: tb/tb_fft_magnitude_pipe.sv
module tb_fft_magnitude_pipe;

    localparam int W     = 20;
    localparam int TAG_W = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] real_in, imag_in;
    logic [TAG_W-1:0]    tag_in;
    logic                last_in, valid_in;
    logic                ready_out;
    logic [W-1:0]        magnitude_out;
    logic [TAG_W-1:0]    tag_out;
    logic                last_out, valid_out;
    logic                ready_in;
    logic [W-1:0]        peak_mag;
    logic [TAG_W-1:0]    peak_tag;
    logic                peak_valid;

    fft_magnitude_pipe #(.W(W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .real_in(real_in), .imag_in(imag_in), .tag_in(tag_in),
        .last_in(last_in), .valid_in(valid_in), .ready_out(ready_out),
        .magnitude_out(magnitude_out), .tag_out(tag_out), .last_out(last_out),
        .valid_out(valid_out), .ready_in(ready_in),
        .peak_mag(peak_mag), .peak_tag(peak_tag), .peak_valid(peak_valid)
    );

    always #5 clk = ~clk;

    // ready_in: 0 = always high, 1 = toggling, 2 = held low
    int   rmode = 0;
    logic tog   = 1'b1;
    always @(posedge clk) begin
        #2;
        tog = ~tog;
    end
    assign ready_in = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'b0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [W-1:0]     mag;
        logic [TAG_W-1:0] tag;
        logic             last;
    } exp_t;
    typedef struct packed {
        logic [W-1:0]     mag;
        logic [TAG_W-1:0] tag;
    } pk_t;

    exp_t exp_q[$];
    pk_t  pk_q[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, want);
        end
    endtask

    function automatic logic [W-1:0] ref_mag(input longint re, input longint im);
        longint n, lo, hi, mid;
        n  = re * re + im * im;
        lo = 0;
        hi = longint'(1) << 21;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid - 1;
        end
`ifdef FFT_MAG_ROUND_EN
        if (n - lo * lo > lo) lo = lo + 1;
`endif
        return W'(lo);
    endfunction

    // Output monitor / scoreboard
    logic              prev_stall = 1'b0;
    logic [W+TAG_W:0]  prev_out;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {valid_out, magnitude_out, tag_out, last_out}, {1'b1, prev_out});
            if (valid_out && !ready_in)
                chk("ready_low_when_stalled", ready_out, 0);
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", valid_out, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("magnitude", magnitude_out, e.mag);
                    chk("tag", tag_out, e.tag);
                    chk("last", last_out, e.last);
                end
            end
            if (peak_valid) begin
                if (pk_q.size() == 0) begin
                    chk("spurious_peak_valid", peak_valid, 0);
                end else begin
                    pk_t p;
                    p = pk_q.pop_front();
                    chk("peak_mag", peak_mag, p.mag);
                    chk("peak_tag", peak_tag, p.tag);
                end
            end
            prev_stall = valid_out && !ready_in;
            prev_out   = {magnitude_out, tag_out, last_out};
        end
    end

    task automatic send(input logic signed [W-1:0] re, input logic signed [W-1:0] im,
                        input logic [TAG_W-1:0] tg, input logic lst, input logic [W-1:0] want);
        int   n   = 0;
        logic acc = 1'b0;
        real_in  = re;
        imag_in  = im;
        tag_in   = tg;
        last_in  = lst;
        valid_in = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
            n++;
        end
        valid_in = 1'b0;
        chk("accept", acc, 1);
        if (acc) exp_q.push_back('{mag: want, tag: tg, last: lst});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pk_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_outputs", exp_q.size(), 0);
        chk("drain_peaks", pk_q.size(), 0);
    endtask

    // Directed vectors with hand-computed magnitudes
    int t2_re [12] = '{-524288,  2, 0, 524287,  0, -1,  5, -7, 2, 524287, -524288,  3};
    int t2_im [12] = '{-524288,  3, 0,      0, -1, -1, 12, 24, 2, 524287,       0, -4};
`ifdef FFT_MAG_ROUND_EN
    int t2_mag[12] = '{ 741455,  4, 0, 524287,  1,  1, 13, 25, 3, 741454,  524288,  5};
`else
    int t2_mag[12] = '{ 741455,  3, 0, 524287,  1,  1, 13, 25, 2, 741453,  524288,  5};
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic signed [W-1:0] r, q;

        rst      = 1'b0;
        valid_in = 1'b0;
        real_in  = '0;
        imag_in  = '0;
        tag_in   = '0;
        last_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_magnitude", magnitude_out, 0);
        chk("rst_tag_out", tag_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_peak_tag", peak_tag, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_ready_out", ready_out, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single sample latency: 3,4 -> 5 after 24 cycles
        real_in  = 3;
        imag_in  = 4;
        tag_in   = 5;
        last_in  = 1'b0;
        valid_in = 1'b1;
        @(negedge clk);
        chk("t1_ready", ready_out, 1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        exp_q.push_back('{mag: 5, tag: 5, last: 1'b0});
        n = 0;
        while (!valid_out && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t1_latency", n, 24);
        @(posedge clk);
        #1;
        drain();

        // Directed corner values, back to back
        for (int i = 0; i < 12; i++)
            send(W'(t2_re[i]), W'(t2_im[i]), TAG_W'(16 + i), 1'b0, W'(t2_mag[i]));
        drain();

        // 64 back-to-back samples with ready_in toggling
        rmode = 1;
        for (int i = 0; i < 64; i++) begin
            r = W'($urandom());
            q = W'($urandom());
            send(r, q, TAG_W'(i), 1'b0, ref_mag(r, q));
        end
        drain();
        rmode = 0;

        // Random mix of full-range and small values against the model
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) begin
                r = W'($urandom());
                q = W'($urandom());
            end else begin
                r = W'(int'($urandom_range(0, 40)) - 20);
                q = W'(int'($urandom_range(0, 40)) - 20);
            end
            send(r, q, TAG_W'($urandom()), 1'b0, ref_mag(r, q));
        end
        drain();

        // Reset with samples in flight and outputs already emerging
        for (int i = 0; i < 30; i++) begin
            r = W'(100 + i);
            send(r, 0, TAG_W'(i), (i == 29), W'(100 + i));
        end
        chk("pre_rst_valid_out", valid_out, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid_out", valid_out, 0);
        chk("async_rst_peak_valid", peak_valid, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_no_outputs", exp_q.size(), 0);
        chk("post_rst_peak_mag", peak_mag, 0);

        // Peak frames: {7,12,12,3}, single bin 2, {0,0}
        pk_q.push_back('{mag: 12, tag: 1});
        pk_q.push_back('{mag: 2,  tag: 9});
        pk_q.push_back('{mag: 0,  tag: 4});
        send(0,   -7, 0, 1'b0, 7);
        send(12,   0, 1, 1'b0, 12);
        send(0,   12, 2, 1'b0, 12);
        send(-3,   0, 3, 1'b1, 3);
        send(2,    0, 9, 1'b1, 2);
        send(0,    0, 4, 1'b0, 0);
        send(0,    0, 5, 1'b1, 0);
        drain();
        chk("peak_mag_held", peak_mag, 0);
        chk("peak_tag_held", peak_tag, 4);

        // Last bin stalled at the output: peak waits for the transfer
        rmode = 2;
        send(5, 12, 7, 1'b1, 13);
        repeat (40) @(posedge clk);
        #1;
        chk("stalled_valid_out", valid_out, 1);
        chk("stalled_peak_tag", peak_tag, 4);
        pk_q.push_back('{mag: 13, tag: 7});
        rmode = 0;
        drain();
        chk("final_peak_mag", peak_mag, 13);
        chk("final_peak_tag", peak_tag, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
